fp_mul_sched: RTL and testbench

Shares one fixed-latency pipelined fp_mul instance between NREQ requesters. Each requester sends an operand pair over a valid/ready channel. The scheduler grants one pair per cycle by round-robin, drives the multiplier inputs, and tracks every in-flight operation with a tag pipeline. It then returns each product to the requester that issued it through a per-requester result register with valid/ready.

---
 rtl/fp_mul_sched_pkg.sv | 18 +
 rtl/fp_mul_sched_rr_arbiter.sv | 35 +++
 rtl/fp_mul_sched.sv | 113 +++++++++++
 tb/tb_fp_mul_sched.sv | 334 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fp_mul_sched_pkg.sv
// Shared types for the fp_mul scheduler: operand width, id width helper, and the in-flight tag.
package fp_mul_sched_pkg;

  localparam int FP_W = 32;

  function automatic int id_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  // Ids are carried at the width of the largest supported requester count.
  localparam int ID_MAX_W = id_w(8);

  typedef struct packed {
    logic                valid;
    logic [ID_MAX_W-1:0] id;
  } tag_t;

endpackage

// File: rtl/fp_mul_sched_rr_arbiter.sv
// Combinational round-robin pick: first eligible index at or after ptr, then wrapping below it.
module rr_arbiter
  import fp_mul_sched_pkg::*;
#(
  parameter int NREQ = 4
) (
  input  logic [NREQ-1:0]     eligible,
  input  logic [ID_MAX_W-1:0] ptr,
  output logic [NREQ-1:0]     grant,
  output logic [ID_MAX_W-1:0] grant_idx,
  output logic                grant_vld
);

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    grant_vld = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      if (!grant_vld && eligible[i] && (ID_MAX_W'(i) >= ptr)) begin
        grant[i]  = 1'b1;
        grant_idx = ID_MAX_W'(i);
        grant_vld = 1'b1;
      end
    end
    // Wrap-around pass only runs when nothing at or above ptr was eligible.
    for (int i = 0; i < NREQ; i++) begin
      if (!grant_vld && eligible[i]) begin
        grant[i]  = 1'b1;
        grant_idx = ID_MAX_W'(i);
        grant_vld = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fp_mul_sched.sv
// Shares one pipelined fp_mul among NREQ requesters; one issue per cycle, result MUL_LAT+1 cycles after issue.
// A requester is blocked from re-issuing until its held result is consumed, so result registers never overflow.
module fp_mul_sched
  import fp_mul_sched_pkg::*;
#(
  parameter int NREQ    = 4,
  parameter int MUL_LAT = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  input  logic [FP_W*NREQ-1:0] req_a,
  input  logic [FP_W*NREQ-1:0] req_b,
  output logic [NREQ-1:0]      resp_valid,
  input  logic [NREQ-1:0]      resp_ready,
  output logic [FP_W*NREQ-1:0] resp_data,
  output logic [FP_W-1:0]      mul_a,
  output logic [FP_W-1:0]      mul_b,
  input  logic [FP_W-1:0]      mul_ret,
  output logic                 busy
);

  logic [NREQ-1:0]     pending;
  logic [NREQ-1:0]     eligible;
  logic [NREQ-1:0]     grant;
  logic [ID_MAX_W-1:0] grant_idx;
  logic [ID_MAX_W-1:0] ptr;
  logic                issue;
  logic [FP_W-1:0]     sel_a;
  logic [FP_W-1:0]     sel_b;
  tag_t                tag_q [MUL_LAT+1];
  logic                cap_vld;
  logic [ID_MAX_W-1:0] cap_id;

  assign eligible  = req_valid & ~pending;
  assign req_ready = grant;
  assign busy      = |pending;
  assign cap_vld   = tag_q[MUL_LAT].valid;
  assign cap_id    = tag_q[MUL_LAT].id;

  rr_arbiter #(.NREQ(NREQ)) u_arb (
    .eligible  (eligible),
    .ptr       (ptr),
    .grant     (grant),
    .grant_idx (grant_idx),
    .grant_vld (issue)
  );

  always_comb begin
    sel_a = '0;
    sel_b = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant[i]) begin
        sel_a = req_a[FP_W*i +: FP_W];
        sel_b = req_b[FP_W*i +: FP_W];
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mul_a <= '0;
      mul_b <= '0;
      ptr   <= '0;
    end else if (issue) begin
      mul_a <= sel_a;
      mul_b <= sel_b;
      ptr   <= (grant_idx == ID_MAX_W'(NREQ-1)) ? '0 : grant_idx + 1'b1;
    end
  end

  // Tags march in lockstep with the multiplier pipeline, bubbles included.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int s = 0; s <= MUL_LAT; s++) tag_q[s] <= '0;
    end else begin
      tag_q[0].valid <= issue;
      tag_q[0].id    <= grant_idx;
      for (int s = 1; s <= MUL_LAT; s++) tag_q[s] <= tag_q[s-1];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pending    <= '0;
      resp_valid <= '0;
    end else begin
      for (int i = 0; i < NREQ; i++) begin
        if (grant[i])
          pending[i] <= 1'b1;
        else if (resp_valid[i] && resp_ready[i])
          pending[i] <= 1'b0;

        if (cap_vld && (cap_id == ID_MAX_W'(i)))
          resp_valid[i] <= 1'b1;
        else if (resp_valid[i] && resp_ready[i])
          resp_valid[i] <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < NREQ; i++) begin
      if (cap_vld && (cap_id == ID_MAX_W'(i)))
        resp_data[FP_W*i +: FP_W] <= mul_ret;
    end
  end

  cap_no_overwrite: assert property (@(posedge clk) disable iff (!rst)
    cap_vld |-> !(|(resp_valid & (NREQ'(1) << cap_id))));

endmodule

// File: tb/tb_fp_mul_sched.sv
// Directed bench for fp_mul_sched with a 3-stage behavioural multiplier in place of fp_mul.
module tb_fp_mul_sched;

  localparam int NREQ    = 4;
  localparam int MUL_LAT = 3;

  logic              clk = 1'b0;
  logic              rst;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ-1:0]   req_ready;
  logic [32*NREQ-1:0] req_a;
  logic [32*NREQ-1:0] req_b;
  logic [NREQ-1:0]   resp_valid;
  logic [NREQ-1:0]   resp_ready;
  logic [32*NREQ-1:0] resp_data;
  logic [31:0]       mul_a;
  logic [31:0]       mul_b;
  logic [31:0]       mul_ret;
  logic              busy;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  fp_mul_sched #(.NREQ(NREQ), .MUL_LAT(MUL_LAT)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_a      (req_a),
    .req_b      (req_b),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_data  (resp_data),
    .mul_a      (mul_a),
    .mul_b      (mul_b),
    .mul_ret    (mul_ret),
    .busy       (busy)
  );

  // Exact-product multiply for normal operands (sufficient for the vectors used here).
  function automatic logic [31:0] fmul(input logic [31:0] a, input logic [31:0] b);
    logic [47:0] m;
    logic [9:0]  e;
    logic        s;
    s = a[31] ^ b[31];
    if (a[30:0] == 31'd0 || b[30:0] == 31'd0) return {s, 31'd0};
    m = {1'b1, a[22:0]} * {1'b1, b[22:0]};
    e = {2'b00, a[30:23]} + {2'b00, b[30:23]} - 10'd127;
    if (m[47]) return {s, e[7:0] + 8'd1, m[46:24]};
    return {s, e[7:0], m[45:23]};
  endfunction

  logic [31:0] p1, p2, p3;
  always @(posedge clk) begin
    p1 <= fmul(mul_a, mul_b);
    p2 <= p1;
    p3 <= p2;
  end
  assign mul_ret = p3;

  task automatic set_ops(input int i, input logic [31:0] a, input logic [31:0] b);
    req_a[32*i +: 32] = a;
    req_b[32*i +: 32] = b;
  endtask

  task automatic do_reset();
    rst        = 1'b0;
    req_valid  = '0;
    resp_ready = '0;
    req_a      = '0;
    req_b      = '0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic wait_resp(input int i, input string name);
    for (int n = 0; n < 20 && !resp_valid[i]; n++) begin
      @(posedge clk);
      @(negedge clk);
    end
    checks++;
    if (resp_valid[i] !== 1'b1) begin
      errors++;
      $display("FAIL %s timeout resp_valid[%0d]=%b required 1", name, i, resp_valid[i]);
    end
  endtask

  task automatic test_reset();
    rst        = 1'b0;
    req_valid  = '0;
    resp_ready = '0;
    req_a      = '0;
    req_b      = '0;
    #2;
    checks++;
    if (resp_valid !== 4'b0000) begin errors++; $display("FAIL reset_resp_valid got %b want 0000", resp_valid); end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
    checks++;
    if (mul_a !== 32'd0 || mul_b !== 32'd0) begin errors++; $display("FAIL reset_mul got %h/%h want 0/0", mul_a, mul_b); end
    checks++;
    if (req_ready !== 4'b0000) begin errors++; $display("FAIL reset_req_ready got %b want 0000", req_ready); end
    do_reset();
  endtask

  task automatic test_single();
    do_reset();
    set_ops(0, 32'h3FC00000, 32'h40000000);
    req_valid = 4'b0001;
    #1;
    checks++;
    if (req_ready !== 4'b0001) begin errors++; $display("FAIL single_ready got %b want 0001", req_ready); end
    @(posedge clk);
    @(negedge clk);
    req_valid = '0;
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL single_busy_issue got %b want 1", busy); end
    for (int k = 1; k <= 4; k++) begin
      @(posedge clk);
      @(negedge clk);
      checks++;
      if (resp_valid[0] !== (k == 4)) begin
        errors++;
        $display("FAIL single_latency cycle %0d resp_valid[0]=%b want %b", k, resp_valid[0], (k == 4));
      end
    end
    checks++;
    if (resp_data[31:0] !== 32'h40400000) begin errors++; $display("FAIL single_data got %h want 40400000", resp_data[31:0]); end
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL single_busy_held got %b want 1", busy); end
    resp_ready = 4'b0001;
    @(posedge clk);
    @(negedge clk);
    resp_ready = '0;
    checks++;
    if (resp_valid !== 4'b0000 || busy !== 1'b0) begin
      errors++;
      $display("FAIL single_consume resp_valid=%b busy=%b want 0000/0", resp_valid, busy);
    end
  endtask

  task automatic test_all_four();
    logic [31:0] exp_d [4];
    logic [3:0]  exp_rdy;
    logic [3:0]  exp_vld;
    do_reset();
    set_ops(0, 32'h40000000, 32'h40400000); exp_d[0] = 32'h40C00000;
    set_ops(1, 32'hBF800000, 32'h40800000); exp_d[1] = 32'hC0800000;
    set_ops(2, 32'h3F800000, 32'h3F800000); exp_d[2] = 32'h3F800000;
    set_ops(3, 32'h3F000000, 32'h41000000); exp_d[3] = 32'h40800000;
    resp_ready = 4'hF;
    req_valid  = 4'hF;
    for (int t = 0; t < 10; t++) begin
      if (t >= 1 && t <= 4) req_valid[t-1] = 1'b0;
      #1;
      exp_rdy = (t < 4) ? (4'b0001 << t) : 4'b0000;
      checks++;
      if (req_ready !== exp_rdy) begin errors++; $display("FAIL all4_grant t=%0d got %b want %b", t, req_ready, exp_rdy); end
      exp_vld = '0;
      for (int c = 0; c < 4; c++) if (t == c + 5) exp_vld[c] = 1'b1;
      checks++;
      if (resp_valid !== exp_vld) begin errors++; $display("FAIL all4_resp_valid t=%0d got %b want %b", t, resp_valid, exp_vld); end
      for (int c = 0; c < 4; c++) begin
        if (t == c + 5) begin
          checks++;
          if (resp_data[32*c +: 32] !== exp_d[c]) begin
            errors++;
            $display("FAIL all4_data[%0d] got %h want %h", c, resp_data[32*c +: 32], exp_d[c]);
          end
        end
      end
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  task automatic test_backpressure();
    int ngrant;
    do_reset();
    set_ops(0, 32'h3F800000, 32'h3F800000);
    set_ops(1, 32'h40000000, 32'h40400000);
    set_ops(2, 32'h3F000000, 32'h41000000);
    resp_ready = 4'b1101;
    req_valid  = 4'b0010;
    wait_resp(1, "bp_first");
    checks++;
    if (resp_data[63:32] !== 32'h40C00000) begin errors++; $display("FAIL bp_data got %h want 40C00000", resp_data[63:32]); end
    req_valid = 4'b0111;
    ngrant = 0;
    for (int j = 0; j < 10; j++) begin
      #1;
      checks++;
      if (req_ready[1] !== 1'b0) begin errors++; $display("FAIL bp_ready1 cycle %0d got %b want 0", j, req_ready[1]); end
      checks++;
      if (resp_valid[1] !== 1'b1 || resp_data[63:32] !== 32'h40C00000) begin
        errors++;
        $display("FAIL bp_hold cycle %0d valid=%b data=%h want 1/40C00000", j, resp_valid[1], resp_data[63:32]);
      end
      if (req_ready[0] || req_ready[2]) ngrant++;
      @(posedge clk);
      @(negedge clk);
    end
    checks++;
    if (ngrant !== 4) begin errors++; $display("FAIL bp_others_grants got %0d want 4", ngrant); end
    req_valid = '0;
  endtask

  task automatic test_fairness();
    int       ngr;
    int       exp_next;
    logic [3:0] exp_g;
    do_reset();
    set_ops(0, 32'h3F800000, 32'h40000000);
    set_ops(2, 32'h40000000, 32'h40000000);
    resp_ready = 4'hF;
    req_valid  = 4'b0101;
    ngr = 0;
    exp_next = 0;
    for (int j = 0; j < 30; j++) begin
      #1;
      if (req_ready != 4'b0000) begin
        exp_g = (exp_next == 0) ? 4'b0001 : 4'b0100;
        checks++;
        if (req_ready !== exp_g) begin errors++; $display("FAIL fair_order grant %0d got %b want %b", ngr, req_ready, exp_g); end
        exp_next = (exp_next == 0) ? 2 : 0;
        ngr++;
      end
      @(posedge clk);
      @(negedge clk);
    end
    checks++;
    if (ngr !== 10) begin errors++; $display("FAIL fair_count got %0d want 10", ngr); end
    req_valid = '0;
  endtask

  task automatic test_same_cycle();
    do_reset();
    set_ops(3, 32'h3F800000, 32'h3F800000);
    req_valid = 4'b1000;
    #1;
    checks++;
    if (req_ready !== 4'b1000) begin errors++; $display("FAIL same_first_grant got %b want 1000", req_ready); end
    @(posedge clk);
    @(negedge clk);
    req_valid = '0;
    wait_resp(3, "same_wait");
    checks++;
    if (resp_data[127:96] !== 32'h3F800000) begin errors++; $display("FAIL same_data got %h want 3F800000", resp_data[127:96]); end
    req_valid  = 4'b1000;
    resp_ready = 4'b1000;
    #1;
    checks++;
    if (req_ready !== 4'b0000) begin errors++; $display("FAIL same_no_grant got %b want 0000", req_ready); end
    @(posedge clk);
    @(negedge clk);
    resp_ready = '0;
    #1;
    checks++;
    if (req_ready !== 4'b1000 || resp_valid[3] !== 1'b0) begin
      errors++;
      $display("FAIL same_next_grant req_ready=%b resp_valid[3]=%b want 1000/0", req_ready, resp_valid[3]);
    end
    @(posedge clk);
    @(negedge clk);
    req_valid = '0;
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL same_reissue_busy got %b want 1", busy); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    set_ops(0, 32'h40000000, 32'h40000000);
    set_ops(1, 32'h40400000, 32'h40000000);
    set_ops(2, 32'h3F800000, 32'h40800000);
    resp_ready = 4'hF;
    req_valid  = 4'b0111;
    for (int j = 0; j < 3; j++) begin
      @(posedge clk);
      @(negedge clk);
    end
    req_valid = '0;
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL mid_busy_before got %b want 1", busy); end
    #2;
    rst = 1'b0;
    #1;
    checks++;
    if (busy !== 1'b0 || resp_valid !== 4'b0000) begin
      errors++;
      $display("FAIL mid_async_clear busy=%b resp_valid=%b want 0/0000", busy, resp_valid);
    end
    checks++;
    if (mul_a !== 32'd0) begin errors++; $display("FAIL mid_mul_a got %h want 0", mul_a); end
    @(negedge clk);
    rst = 1'b1;
    for (int k = 0; k < MUL_LAT + 2; k++) begin
      #1;
      checks++;
      if (resp_valid !== 4'b0000) begin errors++; $display("FAIL mid_stale cycle %0d resp_valid=%b want 0000", k, resp_valid); end
      @(posedge clk);
      @(negedge clk);
    end
    req_valid = 4'b1001;
    #1;
    checks++;
    if (req_ready !== 4'b0001) begin errors++; $display("FAIL mid_ptr_restart got %b want 0001", req_ready); end
    @(posedge clk);
    @(negedge clk);
    req_valid = '0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_all_four();
    test_backpressure();
    test_fairness();
    test_same_cycle();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not complete");
    $fatal(1);
  end

endmodule
